// File: rtl/ghost_mode_pkg.sv
// Ghost behaviour types shared by the mode controller,
// movement and sprite units.
package ghost_mode_pkg;

   typedef enum logic [1:0] {
      MODE_SCATTER = 2'd0,
      MODE_CHASE   = 2'd1,
      MODE_FRIGHT  = 2'd2,
      MODE_EATEN   = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      G_NORMAL = 2'd0,
      G_FRIGHT = 2'd1,
      G_EATEN  = 2'd2
   } ghost_st_t;

   function automatic mode_t phase_mode(input logic chase);
      return chase ? MODE_CHASE : MODE_SCATTER;
   endfunction

endpackage

// File: rtl/ghost_fsm.sv
// Per-ghost NORMAL / FRIGHTENED / EATEN mode FSM with
// registered mode, frightened and reverse outputs.
module ghost_fsm
   import ghost_mode_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       phase_chase,
   input  logic       phase_flip,
   input  logic       pellet,
   input  logic       expire,
   input  logic       eaten,
   input  logic       home,
   output logic [1:0] mode,
   output logic       frightened,
   output logic       reverse
);

   ghost_st_t state;

   // phase_chase is the phase value for the coming cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= G_NORMAL;
         mode       <= MODE_SCATTER;
         frightened <= 1'b0;
         reverse    <= 1'b0;
      end else begin
         reverse <= 1'b0;
         unique case (state)
            G_NORMAL: begin
               if (pellet) begin
                  state      <= G_FRIGHT;
                  mode       <= MODE_FRIGHT;
                  frightened <= 1'b1;
                  reverse    <= 1'b1;
               end else begin
                  mode    <= phase_mode(phase_chase);
                  reverse <= phase_flip;
               end
            end
            G_FRIGHT: begin
               if (eaten) begin
                  state      <= G_EATEN;
                  mode       <= MODE_EATEN;
                  frightened <= 1'b0;
               end else if (pellet) begin
                  reverse <= 1'b1;
               end else if (expire) begin
                  state      <= G_NORMAL;
                  mode       <= phase_mode(phase_chase);
                  frightened <= 1'b0;
               end
            end
            G_EATEN: begin
               if (home) begin
                  state <= G_NORMAL;
                  mode  <= phase_mode(phase_chase);
               end
            end
            default: begin
               state      <= G_NORMAL;
               mode       <= MODE_SCATTER;
               frightened <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/ghost_mode_ctrl.sv
// Ghost behaviour controller: scatter/chase phase timer,
// shared fright timer with warning flash, one mode FSM per ghost.
module ghost_mode_ctrl
   import ghost_mode_pkg::*;
#(
   parameter int N_GHOSTS      = 4,
   parameter int TW            = 8,
   parameter int SCATTER_TICKS = 32,
   parameter int CHASE_TICKS   = 96,
   parameter int FRIGHT_TICKS  = 64,
   parameter int FLASH_TICKS   = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  tick,
   input  logic                  power_pellet,
   input  logic [N_GHOSTS-1:0]   ghost_eaten,
   input  logic [N_GHOSTS-1:0]   ghost_home,
   output logic [2*N_GHOSTS-1:0] mode,
   output logic [N_GHOSTS-1:0]   frightened,
   output logic [N_GHOSTS-1:0]   reverse,
   output logic                  phase_chase,
   output logic                  flashing
);

   localparam int TMAX = (2 ** TW) - 1;

   localparam logic [TW-1:0] SC_LAST = TW'(SCATTER_TICKS - 1);
   localparam logic [TW-1:0] CH_LAST = TW'(CHASE_TICKS - 1);
   localparam logic [TW-1:0] FR_LOAD = TW'(FRIGHT_TICKS);
   localparam logic [TW-1:0] FL_MAX  = TW'(FLASH_TICKS);
   localparam logic [TW-1:0] ONE     = TW'(1);

   if (N_GHOSTS < 1) begin : g_chk_n
      $error("ghost_mode_ctrl: N_GHOSTS must be >= 1");
   end
   if (SCATTER_TICKS < 1 || SCATTER_TICKS > TMAX) begin : g_chk_sc
      $error("ghost_mode_ctrl: SCATTER_TICKS out of range");
   end
   if (CHASE_TICKS < 1 || CHASE_TICKS > TMAX) begin : g_chk_ch
      $error("ghost_mode_ctrl: CHASE_TICKS out of range");
   end
   if (FRIGHT_TICKS < 1 || FRIGHT_TICKS > TMAX) begin : g_chk_fr
      $error("ghost_mode_ctrl: FRIGHT_TICKS out of range");
   end
   if (FLASH_TICKS > FRIGHT_TICKS) begin : g_chk_fl
      $error("ghost_mode_ctrl: FLASH_TICKS exceeds FRIGHT_TICKS");
   end

   logic [TW-1:0] phase_cnt;
   logic [TW-1:0] fright_cnt;
   logic [TW-1:0] fright_nxt;
   logic          fright_on;
   logic          phase_run;
   logic          phase_last;
   logic          phase_flip;
   logic          phase_nxt;
   logic          expire;

   assign fright_on  = |fright_cnt;
   assign phase_run  = tick & ~fright_on;
   assign phase_last = phase_chase ? (phase_cnt == CH_LAST)
                                   : (phase_cnt == SC_LAST);
   assign phase_flip = phase_run & phase_last;
   assign phase_nxt  = phase_chase ^ phase_flip;
   assign expire     = tick & (fright_cnt == ONE) & ~power_pellet;

   always_comb begin
      fright_nxt = fright_cnt;
      if (power_pellet)
         fright_nxt = FR_LOAD;
      else if (tick && fright_on)
         fright_nxt = fright_cnt - ONE;
   end

   // flashing tracks the new fright count so it lines up with frightened
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_chase <= 1'b0;
         phase_cnt   <= '0;
         fright_cnt  <= '0;
         flashing    <= 1'b0;
      end else begin
         phase_chase <= phase_nxt;
         if (phase_run)
            phase_cnt <= phase_flip ? '0 : phase_cnt + ONE;
         fright_cnt <= fright_nxt;
         flashing   <= (|fright_nxt) & (fright_nxt <= FL_MAX);
      end
   end

   for (genvar g = 0; g < N_GHOSTS; g++) begin : g_ghost
      ghost_fsm u_fsm (
         .clk         (clk),
         .reset       (reset),
         .phase_chase (phase_nxt),
         .phase_flip  (phase_flip),
         .pellet      (power_pellet),
         .expire      (expire),
         .eaten       (ghost_eaten[g]),
         .home        (ghost_home[g]),
         .mode        (mode[2*g+:2]),
         .frightened  (frightened[g]),
         .reverse     (reverse[g])
      );
   end

endmodule

// File: tb/tb_ghost_mode_ctrl.sv
// Bench for ghost_mode_ctrl: per-cycle model compare plus
// directed scenarios with literal expectations.
module tb_ghost_mode_ctrl;

   localparam int NG      = 4;
   localparam int SCATTER = 32;
   localparam int CHASE   = 96;
   localparam int FRIGHT  = 64;
   localparam int FLASH   = 16;

   logic          clk;
   logic          reset;
   logic          tick;
   logic          power_pellet;
   logic [NG-1:0] ghost_eaten;
   logic [NG-1:0] ghost_home;
   logic [2*NG-1:0] mode;
   logic [NG-1:0] frightened;
   logic [NG-1:0] reverse;
   logic          phase_chase;
   logic          flashing;

   int n_chk  = 0;
   int n_fail = 0;

   ghost_mode_ctrl #(
      .N_GHOSTS      (NG),
      .TW            (8),
      .SCATTER_TICKS (SCATTER),
      .CHASE_TICKS   (CHASE),
      .FRIGHT_TICKS  (FRIGHT),
      .FLASH_TICKS   (FLASH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick),
      .power_pellet (power_pellet),
      .ghost_eaten  (ghost_eaten),
      .ghost_home   (ghost_home),
      .mode         (mode),
      .frightened   (frightened),
      .reverse      (reverse),
      .phase_chase  (phase_chase),
      .flashing     (flashing)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Model: 0=normal, 1=frightened, 2=eaten per ghost
   int m_pc, m_fc, m_st[NG];
   bit m_ph, m_rev[NG];

   always @(posedge clk or posedge reset) begin : model
      int dur, nfc, st;
      bit flip, expire, rv;
      if (reset) begin
         m_ph <= 1'b0;
         m_pc <= 0;
         m_fc <= 0;
         for (int i = 0; i < NG; i++) begin
            m_st[i]  <= 0;
            m_rev[i] <= 1'b0;
         end
      end else begin
         dur    = m_ph ? CHASE : SCATTER;
         flip   = tick && m_fc == 0 && m_pc == dur - 1;
         expire = tick && m_fc == 1 && !power_pellet;
         for (int i = 0; i < NG; i++) begin
            st = m_st[i];
            rv = 1'b0;
            if (st == 0) begin
               rv = flip || power_pellet;
               if (power_pellet) st = 1;
            end else if (st == 1) begin
               if (ghost_eaten[i]) st = 2;
               else if (power_pellet) rv = 1'b1;
               else if (expire) st = 0;
            end else if (ghost_home[i]) begin
               st = 0;
            end
            m_st[i]  <= st;
            m_rev[i] <= rv;
         end
         if (tick && m_fc == 0) m_pc <= flip ? 0 : m_pc + 1;
         if (flip) m_ph <= !m_ph;
         nfc = m_fc;
         if (power_pellet) nfc = FRIGHT;
         else if (tick && m_fc != 0) nfc = m_fc - 1;
         m_fc <= nfc;
      end
   end

   always @(negedge clk) begin : compare
      logic [2*NG-1:0] em;
      logic [NG-1:0]   ef, er;
      if (!reset) begin
         for (int i = 0; i < NG; i++) begin
            em[2*i+:2] = (m_st[i] == 0) ? {1'b0, m_ph}
                       : (m_st[i] == 1) ? 2'd2 : 2'd3;
            ef[i] = (m_st[i] == 1);
            er[i] = m_rev[i];
         end
         chk("mdl_mode", 32'(mode), 32'(em));
         chk("mdl_fright", 32'(frightened), 32'(ef));
         chk("mdl_reverse", 32'(reverse), 32'(er));
         chk("mdl_phase", 32'(phase_chase), 32'(m_ph));
         chk("mdl_flash", 32'(flashing),
             32'(m_fc != 0 && m_fc <= FLASH));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      tick = 1'b1;
      power_pellet = 1'b0;
      repeat (n) cyc();
   endtask

   task automatic pellet(input logic t);
      tick = t;
      power_pellet = 1'b1;
      cyc();
      power_pellet = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      tick = 1'b0;
      power_pellet = 1'b0;
      ghost_eaten = '0;
      ghost_home = '0;
      cyc();
      cyc();
      chk("rst_mode", 32'(mode), 32'h00);
      chk("rst_fright", 32'(frightened), 32'h0);
      chk("rst_rev", 32'(reverse), 32'h0);
      chk("rst_phase", 32'(phase_chase), 32'h0);
      reset = 1'b0;

      // phase timer: scatter 32, chase 96
      ticks(31);
      chk("t1_sc31", 32'(phase_chase), 32'h0);
      ticks(1);
      chk("t1_chase", 32'(phase_chase), 32'h1);
      chk("t1_rev", 32'(reverse), 32'hF);
      chk("t1_mode", 32'(mode), 32'h55);
      ticks(1);
      chk("t1_rev_end", 32'(reverse), 32'h0);
      ticks(94);
      chk("t1_ch95", 32'(phase_chase), 32'h1);
      ticks(1);
      chk("t1_scatter", 32'(phase_chase), 32'h0);
      chk("t1_rev2", 32'(reverse), 32'hF);

      // pellet at phase_cnt=10
      ticks(10);
      pellet(1'b1);
      chk("t2_fright", 32'(frightened), 32'hF);
      chk("t2_mode", 32'(mode), 32'hAA);
      chk("t2_rev", 32'(reverse), 32'hF);
      ticks(47);
      chk("t2_noflash", 32'(flashing), 32'h0);
      ticks(1);
      chk("t2_flash", 32'(flashing), 32'h1);
      ticks(15);
      chk("t2_last", 32'(frightened), 32'hF);
      ticks(1);
      chk("t2_expired", 32'(frightened), 32'h0);
      chk("t2_mode_n", 32'(mode), 32'h00);
      chk("t2_rev_none", 32'(reverse), 32'h0);
      ticks(20);
      chk("t2_pc31", 32'(phase_chase), 32'h0);
      ticks(1);
      chk("t2_resume", 32'(phase_chase), 32'h1);

      // eaten ghost 1, pellet while eaten, then home
      pellet(1'b1);
      ghost_eaten = 4'b0010;
      ticks(1);
      ghost_eaten = '0;
      chk("t3_eaten", 32'(mode), 32'hAE);
      chk("t3_fright", 32'(frightened), 32'hD);
      pellet(1'b0);
      chk("t3_stay", 32'(mode), 32'hAE);
      chk("t3_rev", 32'(reverse), 32'hD);
      ghost_home = 4'b0010;
      tick = 1'b0;
      cyc();
      ghost_home = '0;
      chk("t3_home", 32'(mode), 32'hA6);

      // pellet with the expiring tick
      ticks(63);
      chk("t4_fc1", 32'(frightened), 32'hD);
      pellet(1'b1);
      chk("t4_reload", 32'(frightened), 32'hF);
      chk("t4_mode", 32'(mode), 32'hAA);
      chk("t4_noflash", 32'(flashing), 32'h0);
      ticks(47);
      chk("t4_fc17", 32'(flashing), 32'h0);
      ticks(1);
      chk("t4_fc16", 32'(flashing), 32'h1);

      // eaten beats pellet in the same cycle
      ghost_eaten = 4'b0001;
      pellet(1'b0);
      ghost_eaten = '0;
      chk("t5_mode", 32'(mode), 32'hAB);
      chk("t5_rev", 32'(reverse), 32'hE);
      chk("t5_reload", 32'(flashing), 32'h0);
      ticks(48);
      chk("t5_fc16", 32'(flashing), 32'h1);

      // asynchronous reset mid-fright
      #2;
      reset = 1'b1;
      #1;
      chk("t6_mode", 32'(mode), 32'h00);
      chk("t6_fright", 32'(frightened), 32'h0);
      chk("t6_flash", 32'(flashing), 32'h0);
      chk("t6_rev", 32'(reverse), 32'h0);
      chk("t6_phase", 32'(phase_chase), 32'h0);
      cyc();
      reset = 1'b0;

      // phase flip and pellet together
      ticks(31);
      chk("t7_pre", 32'(phase_chase), 32'h0);
      pellet(1'b1);
      chk("t7_phase", 32'(phase_chase), 32'h1);
      chk("t7_rev", 32'(reverse), 32'hF);
      chk("t7_mode", 32'(mode), 32'hAA);
      tick = 1'b0;
      cyc();
      chk("t7_rev_one", 32'(reverse), 32'h0);
      ticks(5);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
